// File: rtl/imm_pkg.sv
// Shared encodings for the pipelined immediate generator: format selects and RISC-V opcodes.
package imm_pkg;

  // imm_src / fmt encodings
  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_B    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_AUTO = 3'b101;
  localparam logic [2:0] IMM_ZIMM = 3'b110;
  localparam logic [2:0] IMM_RSVD = 3'b111;

  // RISC-V base opcodes that carry an immediate
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // S1 payload; opcode bits are consumed by the resolver and not carried forward
  typedef struct packed {
    logic [31:7] ib;
    logic [2:0]  fmt;
    logic        err;
  } s1_t;

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational format resolver: maps imm_src (or the opcode under AUTO) to fmt/err.
// Latency 0; no flow control. ZIMM select is honoured only when IMM_GEN_ZIMM_EN is defined.
module imm_fmt_decode
  import imm_pkg::*;
(
  input  logic [2:0] imm_src,
  input  logic [6:0] opcode,
  output logic [2:0] fmt,
  output logic       err
);

  always_comb begin
    fmt = IMM_I;
    err = 1'b0;
    case (imm_src)
      IMM_I, IMM_B, IMM_S, IMM_J, IMM_U: fmt = imm_src;
      IMM_AUTO: begin
        case (opcode)
          OP_IMM, OP_LOAD, OP_JALR: fmt = IMM_I;
          OP_STORE:                 fmt = IMM_S;
          OP_BRANCH:                fmt = IMM_B;
          OP_LUI, OP_AUIPC:         fmt = IMM_U;
          OP_JAL:                   fmt = IMM_J;
          default:                  err = 1'b1;
        endcase
      end
`ifdef IMM_GEN_ZIMM_EN
      IMM_ZIMM: fmt = IMM_ZIMM;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage elastic immediate generator: S1 resolves format/err, S2 extends to XLEN.
// Latency 2 cycles, 1 beat/cycle; in_ready = !s1_valid || s1 advancing, outputs hold while stalled.
// Optional CSR zero-extended immediate (select 110) enabled by `define IMM_GEN_ZIMM_EN.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             err,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid;
  s1_t              s1_q;
  logic [TAG_W-1:0] s1_tag;
  logic [2:0]       dec_fmt;
  logic             dec_err;
  logic             s2_free;
  logic             s1_moves;
  logic             accept;
  logic [31:7]      ib;
  logic signed [31:0] raw;
  logic [XLEN-1:0]  imm_ext;

  imm_fmt_decode u_dec (
    .imm_src (imm_src),
    .opcode  (inst[6:0]),
    .fmt     (dec_fmt),
    .err     (dec_err)
  );

  // Handshake depends only on stage state and out_ready, never on in_valid
  assign s2_free  = !out_valid || out_ready;
  assign s1_moves = s1_valid && s2_free;
  assign in_ready = !s1_valid || s1_moves;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_tag   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q     <= '{ib: inst[31:7], fmt: dec_fmt, err: dec_err};
      s1_tag   <= in_tag;
    end else if (s1_moves) begin
      s1_valid <= 1'b0;
    end
  end

  // Build a sign-correct 32-bit immediate, then sign-extend to XLEN
  assign ib = s1_q.ib;

  always_comb begin
    raw = '0;
    if (!s1_q.err) begin
      case (s1_q.fmt)
        IMM_I:    raw = {{20{ib[31]}}, ib[31:20]};
        IMM_S:    raw = {{20{ib[31]}}, ib[31:25], ib[11:7]};
        IMM_B:    raw = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
        IMM_J:    raw = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
        IMM_U:    raw = {ib[31:12], 12'b0};
`ifdef IMM_GEN_ZIMM_EN
        IMM_ZIMM: raw = {27'b0, ib[19:15]};
`endif
        default:  raw = '0;
      endcase
    end
  end

  assign imm_ext = XLEN'(raw);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      imm       <= '0;
      fmt       <= '0;
      err       <= 1'b0;
      out_tag   <= '0;
    end else if (s1_moves) begin
      out_valid <= 1'b1;
      imm       <= imm_ext;
      fmt       <= s1_q.fmt;
      err       <= s1_q.err;
      out_tag   <= s1_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed table-driven bench for imm_gen_pipe at XLEN=32 and XLEN=64 side by side.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] inst = '0;
  logic [2:0]  imm_src = '0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  logic        in_ready32, in_ready64, out_valid32, out_valid64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic        err32, err64;
  logic [3:0]  tag32, tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .inst(inst), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .imm(imm32), .fmt(fmt32), .err(err32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .inst(inst), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .imm(imm64), .fmt(fmt64), .err(err64), .out_tag(tag64)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [2:0]  src;
    logic [3:0]  tag;
    logic [31:0] e32;
    logic [63:0] e64;
    logic [2:0]  fmt;
    logic        err;
    logic        chkf;
  } vec_t;

  localparam int N = 15;
  vec_t vt[N];
  vec_t exp_q[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   stray = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [2:0] s, input logic [3:0] t,
                              input logic [31:0] e32, input logic [63:0] e64,
                              input logic [2:0] f, input logic e, input logic cf);
    vec_t v;
    v = '{inst: i, src: s, tag: t, e32: e32, e64: e64, fmt: f, err: e, chkf: cf};
    return v;
  endfunction

  // Drive one beat; returns just before the accepting posedge
  task automatic send(input vec_t v);
    int b;
    @(negedge clk);
    in_valid = 1'b1; inst = v.inst; imm_src = v.src; in_tag = v.tag;
    #1;
    b = 0;
    while (!in_ready32 && b < 50) begin
      @(negedge clk); #1; b++;
    end
    chk("send_ready", {63'b0, in_ready32}, 64'd1);
    exp_q.push_back(v);
  endtask

  // Scoreboard: every consumed output beat must match the oldest accepted beat
  always begin
    vec_t e;
    @(negedge clk); #2;
    if (!reset && out_valid32 && out_ready) begin
      if (exp_q.size() == 0) begin
        stray++;
      end else begin
        e = exp_q.pop_front();
        chk("valid64", {63'b0, out_valid64}, 64'd1);
        chk("imm32", {32'b0, imm32}, {32'b0, e.e32});
        chk("imm64", imm64, e.e64);
        if (e.chkf) begin
          chk("fmt32", {61'b0, fmt32}, {61'b0, e.fmt});
          chk("fmt64", {61'b0, fmt64}, {61'b0, e.fmt});
        end
        chk("err32", {63'b0, err32}, {63'b0, e.err});
        chk("err64", {63'b0, err64}, {63'b0, e.err});
        chk("tag32", {60'b0, tag32}, {60'b0, e.tag});
        chk("tag64", {60'b0, tag64}, {60'b0, e.tag});
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = mk(32'hFFF00093, IMM_I,    4'd3,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, IMM_I, 1'b0, 1'b1);
    vt[1]  = mk(32'hFE000EE3, IMM_B,    4'd1,  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, IMM_B, 1'b0, 1'b1);
    vt[2]  = mk(32'h001000EF, IMM_J,    4'd2,  32'h00000800, 64'h0000000000000800, IMM_J, 1'b0, 1'b1);
    vt[3]  = mk(32'h123452B7, IMM_AUTO, 4'd4,  32'h12345000, 64'h0000000012345000, IMM_U, 1'b0, 1'b1);
    vt[4]  = mk(32'h800002B7, IMM_AUTO, 4'd5,  32'h80000000, 64'hFFFFFFFF80000000, IMM_U, 1'b0, 1'b1);
    vt[5]  = mk(32'hFFF00093, IMM_RSVD, 4'd6,  32'h0,        64'h0,                IMM_I, 1'b1, 1'b0);
    vt[6]  = mk(32'h00B50533, IMM_AUTO, 4'd7,  32'h0,        64'h0,                IMM_I, 1'b1, 1'b1);
    vt[7]  = mk(32'hFE552C23, IMM_AUTO, 4'd8,  32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, IMM_S, 1'b0, 1'b1);
    vt[8]  = mk(32'h00452283, IMM_AUTO, 4'd9,  32'h00000004, 64'h0000000000000004, IMM_I, 1'b0, 1'b1);
    vt[9]  = mk(32'h800080E7, IMM_AUTO, 4'd10, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, IMM_I, 1'b0, 1'b1);
    vt[10] = mk(32'h00001297, IMM_AUTO, 4'd11, 32'h00001000, 64'h0000000000001000, IMM_U, 1'b0, 1'b1);
    vt[11] = mk(32'hFFFFF037, IMM_U,    4'd12, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, IMM_U, 1'b0, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
    vt[12] = mk(32'h0001D073, IMM_ZIMM, 4'd13, 32'h00000003, 64'h0000000000000003, IMM_ZIMM, 1'b0, 1'b1);
`else
    vt[12] = mk(32'h0001D073, IMM_ZIMM, 4'd13, 32'h0,        64'h0,                IMM_I, 1'b1, 1'b0);
`endif
    vt[13] = mk(32'hFE000EE3, IMM_AUTO, 4'd14, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, IMM_B, 1'b0, 1'b1);
    vt[14] = mk(32'h001000EF, IMM_AUTO, 4'd15, 32'h00000800, 64'h0000000000000800, IMM_J, 1'b0, 1'b1);

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("rst_imm32", {32'b0, imm32}, 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_fmt", {61'b0, fmt32}, 64'd0);
    chk("rst_err", {63'b0, err32}, 64'd0);
    chk("rst_tag", {60'b0, tag32}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {63'b0, in_ready32}, 64'd1);

    // Latency: two edges from accept to out_valid
    send(vt[0]);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("lat_cycle1", {63'b0, out_valid32}, 64'd0);
    @(negedge clk); #2;
    chk("lat_cycle2", {63'b0, out_valid32}, 64'd1);
    @(negedge clk);
    pop_cyc.delete();

    // Full table, back to back with out_ready held high
    for (int i = 0; i < N; i++) send(vt[i]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < 50 && exp_q.size() != 0; b++) @(negedge clk);
    chk("table_drain", 64'(exp_q.size()), 64'd0);
    chk("table_count", 64'(pop_cyc.size()), 64'(N));
    if (pop_cyc.size() == N)
      chk("no_bubble", 64'(pop_cyc[N-1] - pop_cyc[0]), 64'(N - 1));

    // Backpressure: two beats fill the pipe, third must wait
    @(negedge clk);
    out_ready = 1'b0;
    send(vt[1]);
    send(vt[2]);
    @(negedge clk);
    in_valid = 1'b1; inst = vt[3].inst; imm_src = vt[3].src; in_tag = vt[3].tag;
    #1;
    chk("bp_in_ready_low", {63'b0, in_ready32}, 64'd0);
    chk("bp_out_valid", {63'b0, out_valid32}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("bp_hold_imm", {32'b0, imm32}, {32'b0, vt[1].e32});
      chk("bp_hold_tag", {60'b0, tag32}, {60'b0, vt[1].tag});
      chk("bp_hold_ready", {63'b0, in_ready32}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'b0, in_ready32}, 64'd1);
    exp_q.push_back(vt[3]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < 20 && exp_q.size() != 0; b++) @(negedge clk);
    chk("bp_drain", 64'(exp_q.size()), 64'd0);

    // Reset with both stages full discards them
    @(negedge clk);
    out_ready = 1'b0;
    send(vt[4]);
    send(vt[5]);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("mid_rst_in_ready", {63'b0, in_ready32}, 64'd1);
    chk("mid_rst_imm", {32'b0, imm32}, 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    send(vt[12]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < 20 && exp_q.size() != 0; b++) @(negedge clk);
    chk("post_rst_drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("no_stale_beat", 64'(stray), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
